// File: rtl/ram_arb_2to1.sv
// Two-requester round-robin arbiter in front of one single-port OBI-style RAM.
// Responses are routed back through an in-order FIFO of owner IDs.
module ram_arb_2to1 #(
    parameter int AW        = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    m_req,
    input  logic [1:0]    m_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [3:0]    m0_be,
    input  logic [3:0]    m1_be,
    input  logic [31:0]   m0_wdata,
    input  logic [31:0]   m1_wdata,
    output logic [1:0]    m_gnt,
    output logic [1:0]    m_rvalid,
    output logic [31:0]   m_rdata,
    output logic          s_req,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [3:0]    s_be,
    output logic [31:0]   s_wdata,
    input  logic          s_gnt,
    input  logic          s_rvalid,
    input  logic [31:0]   s_rdata,
    output logic          unexp_rsp
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic          lock_q;
    logic          lock_sel_q;
    logic          last_win_q;
    logic          unexp_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          owner_mem [MAX_OUTST];

    logic arb_sel;
    logic sel;
    logic mux_sel;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic pop;
    logic head;

    always_comb begin
        // NOTE: default assignment first so no path leaves arb_sel unassigned (no latch).
        arb_sel = 1'b0;
        case (m_req)
            2'b10:   arb_sel = 1'b1;
            2'b11:   arb_sel = ~last_win_q;
            default: arb_sel = 1'b0;
        endcase
    end

    // A stalled request keeps its owner until the RAM grants it.
    assign sel        = lock_q ? lock_sel_q : arb_sel;
    assign fifo_full  = (count_q == CW'(MAX_OUTST));
    assign fifo_empty = (count_q == '0);
    assign s_req      = lock_q | ((|m_req) & ~fifo_full);
    assign mux_sel    = s_req & sel;

    assign s_we    = mux_sel ? m_we[1]  : m_we[0];
    assign s_addr  = mux_sel ? m1_addr  : m0_addr;
    assign s_be    = mux_sel ? m1_be    : m0_be;
    assign s_wdata = mux_sel ? m1_wdata : m0_wdata;

    assign accept = s_req & s_gnt;
    assign m_gnt  = {accept & sel, accept & ~sel};

    assign pop       = s_rvalid & ~fifo_empty;
    assign head      = owner_mem[rd_ptr_q];
    assign m_rvalid  = {pop & head, pop & ~head};
    assign m_rdata   = s_rdata;
    assign unexp_rsp = unexp_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            last_win_q <= 1'b1;
            unexp_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (s_req && !s_gnt) begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end else if (accept) begin
                lock_q <= 1'b0;
            end

            if (accept) begin
                last_win_q <= sel;
                wr_ptr_q   <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (s_rvalid && fifo_empty) begin
                unexp_q <= 1'b1;
            end
        end
    end

    // NOTE: ID storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_mem[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_ram_arb_2to1.sv
// Self-checking bench for ram_arb_2to1: directed vector table, then random
// traffic against a transaction-level model of arbitration and response routing.
module tb_ram_arb_2to1;

    localparam int MAX_OUTST = 2;
    localparam logic [31:0] A0  = 32'h0000_0010;
    localparam logic [31:0] A1  = 32'h0000_0024;
    localparam logic [31:0] WD1 = 32'hA5A5_1234;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req, m_we;
    logic [31:0] m0_addr, m1_addr;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wdata, m1_wdata;
    logic [1:0]  m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;
    logic        unexp_rsp;

    int n_vec = 0;
    int n_err = 0;

    ram_arb_2to1 #(.AW(32), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_be(m0_be), .m1_be(m1_be),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .unexp_rsp(unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic        gnt;
        logic        rv;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_sreq;
        logic        e_unexp;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [1:0] req, input logic [1:0] we,
                                input logic gnt, input logic rv, input logic [1:0] eg,
                                input logic [1:0] er, input logic es, input logic eu,
                                input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.req = req; v.we = we; v.gnt = gnt; v.rv = rv;
        v.e_gnt = eg; v.e_rv = er; v.e_sreq = es; v.e_unexp = eu; v.e_addr = ea;
        return v;
    endfunction

    // Transaction-level reference state for the random phase.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          mdl_last_win;
    bit          mdl_locked;
    int          mdl_lock_owner;
    int          mdl_owners[$];
    bit          mdl_unexp;
    rsp_t        ram_q[$];
    logic [31:0] mem [16];
    int          last_due;

    bit          r_req [2];
    bit          r_we  [2];
    logic [31:0] r_addr[2];
    logic [3:0]  r_be  [2];
    logic [31:0] r_wd  [2];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_we;

        rst = 1'b1; m_req = 2'b00; m_we = 2'b00;
        m0_addr = A0; m1_addr = A1; m0_be = 4'hF; m1_be = 4'b0011;
        m0_wdata = 32'h0; m1_wdata = WD1;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        //                rst req    we     gnt rv  e_gnt  e_rv   sreq unexp addr
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, A0)); // reset state
        vecs.push_back(mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 1, 0, A0)); // m0 read
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, A0)); // reset
        vecs.push_back(mk(0, 2'b11, 2'b00, 1, 0, 2'b01, 2'b00, 1, 0, A0)); // alternate
        vecs.push_back(mk(0, 2'b11, 2'b00, 1, 1, 2'b10, 2'b01, 1, 0, A1));
        vecs.push_back(mk(0, 2'b11, 2'b00, 1, 1, 2'b01, 2'b10, 1, 0, A0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 1, 1, 2'b10, 2'b01, 1, 0, A1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 0, 0, A0));
        vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 2'b00, 2'b00, 1, 0, A1)); // m1 write, gnt delayed
        vecs.push_back(mk(0, 2'b11, 2'b10, 0, 0, 2'b00, 2'b00, 1, 0, A1));
        vecs.push_back(mk(0, 2'b11, 2'b10, 0, 0, 2'b00, 2'b00, 1, 0, A1));
        vecs.push_back(mk(0, 2'b11, 2'b10, 1, 0, 2'b10, 2'b00, 1, 0, A1));
        vecs.push_back(mk(0, 2'b01, 2'b00, 1, 1, 2'b01, 2'b10, 1, 0, A0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 0, 0, A0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 1, 0, A0)); // fill FIFO
        vecs.push_back(mk(0, 2'b10, 2'b10, 1, 0, 2'b10, 2'b00, 1, 0, A1));
        vecs.push_back(mk(0, 2'b11, 2'b10, 1, 0, 2'b00, 2'b00, 0, 0, A0)); // full blocks
        vecs.push_back(mk(0, 2'b11, 2'b10, 1, 1, 2'b00, 2'b01, 0, 0, A0));
        vecs.push_back(mk(0, 2'b11, 2'b10, 1, 0, 2'b01, 2'b00, 1, 0, A0)); // reasserts
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 0, 0, A0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 0, 0, A0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, A0)); // unexpected rsp
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, A0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, A0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, A0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 1, 0, A0)); // reset mid-traffic
        vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 2'b00, 2'b00, 1, 0, A1));
        vecs.push_back(mk(1, 2'b10, 2'b10, 0, 0, 2'b00, 2'b00, 1, 0, A1));
        vecs.push_back(mk(0, 2'b11, 2'b10, 0, 1, 2'b00, 2'b00, 1, 0, A0));
        vecs.push_back(mk(0, 2'b11, 2'b10, 1, 0, 2'b01, 2'b00, 1, 1, A0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 0, 1, A0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst; m_req = v.req; m_we = v.we;
            s_gnt = v.gnt; s_rvalid = v.rv; s_rdata = 32'hC0DE_0000 + 32'(i);
            e_be = (v.e_addr == A1) ? 4'b0011 : 4'hF;
            e_wd = (v.e_addr == A1) ? WD1 : 32'h0;
            e_we = (v.e_addr == A1) ? v.we[1] : v.we[0];
            @(negedge clk);
            check($sformatf("v%0d m_gnt", i), 32'(m_gnt), 32'(v.e_gnt));
            check($sformatf("v%0d m_rvalid", i), 32'(m_rvalid), 32'(v.e_rv));
            check($sformatf("v%0d s_req", i), 32'(s_req), 32'(v.e_sreq));
            check($sformatf("v%0d unexp_rsp", i), 32'(unexp_rsp), 32'(v.e_unexp));
            check($sformatf("v%0d s_addr", i), s_addr, v.e_addr);
            check($sformatf("v%0d s_we", i), 32'(s_we), 32'(e_we));
            check($sformatf("v%0d s_be", i), 32'(s_be), 32'(e_be));
            check($sformatf("v%0d s_wdata", i), s_wdata, e_wd);
            if (v.e_rv != 2'b00)
                check($sformatf("v%0d m_rdata", i), m_rdata, 32'hC0DE_0000 + 32'(i));
            @(posedge clk);
            #1;
        end

        // Random phase: bench acts as both requesters and the RAM.
        rst = 1'b1; m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0;
        @(posedge clk);
        #1;
        mdl_last_win = 1; mdl_locked = 0; mdl_lock_owner = 0; mdl_unexp = 0;
        mdl_owners.delete(); ram_q.delete(); last_due = 0;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        for (int r = 0; r < 2; r++) begin
            r_req[r] = 0; r_we[r] = 0; r_addr[r] = 0; r_be[r] = 4'hF; r_wd[r] = 0;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit   full, e_sreq, acc;
            int   win, eff;
            logic [1:0] e_g, e_r;
            logic [31:0] rd;

            for (int r = 0; r < 2; r++) begin
                if (!r_req[r]) begin
                    r_req[r]  = ($urandom_range(0, 99) < 55);
                    r_we[r]   = $urandom_range(0, 1) == 1;
                    r_addr[r] = 32'($urandom_range(0, 15) * 4);
                    r_be[r]   = 4'($urandom_range(1, 15));
                    r_wd[r]   = $urandom;
                end
            end
            rst      = ($urandom_range(0, 199) == 0);
            m_req    = {r_req[1], r_req[0]};
            m_we     = {r_we[1], r_we[0]};
            m0_addr  = r_addr[0]; m1_addr = r_addr[1];
            m0_be    = r_be[0];   m1_be   = r_be[1];
            m0_wdata = r_wd[0];   m1_wdata = r_wd[1];
            s_gnt    = !rst && ($urandom_range(0, 99) < 65);
            s_rvalid = (ram_q.size() > 0) && (ram_q[0].due <= cyc);
            s_rdata  = s_rvalid ? ram_q[0].data : $urandom;

            full   = (mdl_owners.size() >= MAX_OUTST);
            e_sreq = mdl_locked || ((m_req != 2'b00) && !full);
            if (mdl_locked)          win = mdl_lock_owner;
            else if (m_req == 2'b11) win = 1 - mdl_last_win;
            else if (m_req == 2'b10) win = 1;
            else                     win = 0;
            eff = e_sreq ? win : 0;
            acc = e_sreq && s_gnt;
            e_g = acc ? 2'(1 << win) : 2'b00;
            e_r = (s_rvalid && mdl_owners.size() > 0) ? 2'(1 << mdl_owners[0]) : 2'b00;

            @(negedge clk);
            check("rnd m_gnt", 32'(m_gnt), 32'(e_g));
            check("rnd m_rvalid", 32'(m_rvalid), 32'(e_r));
            check("rnd s_req", 32'(s_req), 32'(e_sreq));
            check("rnd s_addr", s_addr, r_addr[eff]);
            check("rnd s_we", 32'(s_we), 32'(r_we[eff]));
            check("rnd s_be", 32'(s_be), 32'(r_be[eff]));
            check("rnd s_wdata", s_wdata, r_wd[eff]);
            check("rnd unexp_rsp", 32'(unexp_rsp), 32'(mdl_unexp));
            if (e_r != 2'b00) check("rnd m_rdata", m_rdata, ram_q[0].data);

            @(posedge clk);
            if (rst) begin
                mdl_last_win = 1; mdl_locked = 0; mdl_unexp = 0;
                mdl_owners.delete(); ram_q.delete(); last_due = 0;
            end else begin
                if (s_rvalid) begin
                    if (mdl_owners.size() > 0) void'(mdl_owners.pop_front());
                    else mdl_unexp = 1;
                    void'(ram_q.pop_front());
                end
                if (acc) begin
                    rsp_t rs;
                    int   idx;
                    idx = int'(r_addr[win][5:2]);
                    rd  = mem[idx];
                    if (r_we[win]) begin
                        for (int b = 0; b < 4; b++)
                            if (r_be[win][b]) mem[idx][8*b +: 8] = r_wd[win][8*b +: 8];
                        rd = 32'h0;
                    end
                    rs.due   = cyc + 1 + $urandom_range(0, 2);
                    if (rs.due <= last_due) rs.due = last_due + 1;
                    last_due = rs.due;
                    rs.data  = rd;
                    ram_q.push_back(rs);
                    mdl_owners.push_back(win);
                    mdl_last_win = win;
                    mdl_locked   = 0;
                    r_req[win]   = 0;
                end else if (e_sreq) begin
                    mdl_locked     = 1;
                    mdl_lock_owner = win;
                end
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arb_2to1.md
Name: ram_arb_2to1

Overview:
- Two-requester arbiter sharing one single-port 32-bit RAM slave (OBI-style req/gnt/rvalid) between the core instruction port (m0) and data port (m1) in the FPGA system.
- Round-robin arbitration with request locking until grant.
- An in-order owner-ID FIFO routes each read/write response back to the requester that issued it.
- Sits between the core bus ports and ram_1p-class memories.

Parameters:
- AW, 32, address width of all address ports.
- MAX_OUTST, 2, maximum accepted-but-unresponded transactions. Range 1..4; sets the ID FIFO depth.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- m_req  in  2  per-requester request; bit0=instr, bit1=data.
- m_we  in  2  per-requester write enable.
- m0_addr, m1_addr  in  AW each  requester byte addresses.
- m0_be, m1_be  in  4 each  byte enables.
- m0_wdata, m1_wdata  in  32 each  write data.
- m_gnt  out  2  per-requester grant (combinational).
- m_rvalid  out  2  per-requester response valid.
- m_rdata  out  32  response data, shared, qualified by m_rvalid.
- s_req  out  1  request to RAM.
- s_we  out  1  write enable to RAM.
- s_addr  out  AW  address to RAM.
- s_be  out  4  byte enables to RAM.
- s_wdata  out  32  write data to RAM.
- s_gnt  in  1  RAM grant; may be combinational or arrive cycles after s_req.
- s_rvalid  in  1  RAM response valid; in order, exactly one per accepted transaction.
- s_rdata  in  32  RAM read data.
- unexp_rsp  out  1  sticky flag: s_rvalid seen with empty ID FIFO.

Behaviour:
- Handshake: a transaction is accepted on a cycle with s_req & s_gnt. m_gnt[i] = s_gnt & s_req & (sel==i).
- sel and the lock:
  - sel is a combinational winner unless the lock is held.
  - The lock is set when s_req=1 & s_gnt=0. While locked, sel is frozen and s_* mirrors the locked requester's live inputs; requesters must hold them stable per OBI.
  - The lock clears on the accept cycle.
- Arbitration (unlocked):
  - Only one m_req set -> that requester wins.
  - Both set -> the requester other than last_win wins.
  - last_win updates to the winner on every accept. Reset value = 1, so m0 wins the first tie.
- Issue gating: s_req = (any m_req) & !fifo_full. s_we/s_addr/s_be/s_wdata mux from sel. When s_req=0, the s_* fields hold the sel=0 values (don't-care).
- ID FIFO:
  - Depth MAX_OUTST, 1-bit entries; push sel on accept, pop on s_rvalid.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - fifo_full blocks new requests, but a pending locked request keeps s_req high until granted.
  - Because full is checked before the lock is set, the count never exceeds MAX_OUTST.
- Response routing:
  - m_rvalid[head]=s_rvalid, other bit 0; m_rdata=s_rdata, combinational, zero added latency.
  - With RAM read latency 1, an accept in cycle N gives m_rvalid in N+1.
  - Back-to-back alternating owners must route correctly every cycle.
- Unexpected response: s_rvalid with an empty FIFO -> no m_rvalid, FIFO unchanged, unexp_rsp set to 1 until reset.
- Pointer wrap: read/write pointers wrap modulo MAX_OUTST; count is held separately, width clog2(MAX_OUTST+1).
- Reset (synchronous, rst=1 on a rising edge):
  - FIFO empty; lock=0; last_win=1; unexp_rsp=0.
  - Combinational outputs follow: s_req=0 only if m_req=0. m_gnt=0 and m_rvalid=0 whenever s_gnt/s_rvalid=0.
  - Responses in flight at reset are treated as unexpected afterwards; the integrator guarantees the RAM is also reset.

Test Plan:
- Single m0 read @0x10, RAM latency 1: m_gnt=01 in cycle 0, m_rvalid=01 with m_rdata=mem[4] in cycle 1; m_rvalid never 10.
- Both requesting continuously, s_gnt=1 always: grants alternate 01,10,01,10 starting with m0; each m_rvalid bit follows its grant by 1 cycle.
- m1 write (be=0011, wdata=0xA5A5_1234) under a 3-cycle delayed s_gnt with m0 asserting mid-wait: the s_* fields stay on m1 for all 3 cycles; m1 is granted first, then m0.
- MAX_OUTST=2, s_rvalid held off after 2 accepts: s_req=0 on the 3rd cycle; one s_rvalid -> s_req reasserts the next cycle; responses go to owners in issue order.
- s_rvalid pulse with nothing outstanding: m_rvalid=00, unexp_rsp=1 and stays 1; rst=1 for one cycle -> unexp_rsp=0.
- rst asserted while one transaction is locked and one is outstanding: the next cycle has FIFO count 0 and no lock; the first tie after reset goes to m0.
